ram_sdp_init: RTL and testbench

//   Parametrised simple-dual-port RAM (one write port, one read port) for the RAM verification environment.

---
 rtl/ram_sdp_init.sv | 137 +++++++++++++
 tb/tb_ram_sdp_init.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sdp_init.sv
// Simple-dual-port RAM with byte-enable writes, 1- or 2-cycle registered reads,
// write-first forwarding, and a post-reset init sweep signalled by init_done.
module ram_sdp_init #(
    parameter int unsigned                 DATA_WIDTH = 32,
    parameter int unsigned                 ADDR_WIDTH = 4,
    parameter int unsigned                 DEPTH      = 16,
    parameter int unsigned                 RD_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0]       INIT_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_enb,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_enb,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    init_done,
    output logic                    access_err
);

    localparam int unsigned           NB        = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    generate
        if (DATA_WIDTH % 8 != 0) begin : g_chk_dw
            $error("ram_sdp_init: DATA_WIDTH must be a multiple of 8");
        end
        if (DEPTH > (2 ** ADDR_WIDTH)) begin : g_chk_depth
            $error("ram_sdp_init: DEPTH exceeds 2**ADDR_WIDTH");
        end
        if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_chk_lat
            $error("ram_sdp_init: RD_LATENCY must be 1 or 2");
        end
    endgenerate

    typedef enum logic {S_INIT, S_READY} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   init_cnt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    wr_oor;
    logic                    rd_oor;
    logic                    wr_fire;
    logic                    rd_fire;
    logic                    err_next;
    logic [DATA_WIDTH-1:0]   rd_word;

    logic                    p1_valid;
    logic [DATA_WIDTH-1:0]   p1_data;

    assign wr_oor  = {1'b0, wr_addr} >= DEPTH_W;
    assign rd_oor  = {1'b0, rd_addr} >= DEPTH_W;
    assign wr_fire = (state == S_READY) && wr_enb && !wr_oor;
    assign rd_fire = (state == S_READY) && rd_enb;

    // Any request during the sweep is dropped and flagged; both ports share one pulse.
    assign err_next = (state == S_INIT) ? (wr_enb || rd_enb)
                                        : ((wr_enb && wr_oor) || (rd_enb && rd_oor));

    // Write-first: enabled bytes of a colliding write override the stored word.
    always_comb begin
        rd_word = '0;
        if (!rd_oor) begin
            rd_word = mem[rd_addr];
            if (wr_fire && (wr_addr == rd_addr)) begin
                for (int unsigned i = 0; i < NB; i++) begin
                    if (wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_INIT) begin
            mem[init_cnt] <= INIT_VALUE;
        end else if (wr_fire) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_INIT;
            init_cnt   <= '0;
            init_done  <= 1'b0;
            access_err <= 1'b0;
            p1_valid   <= 1'b0;
            p1_data    <= '0;
        end else begin
            access_err <= err_next;
            p1_valid   <= rd_fire;
            if (rd_fire) p1_data <= rd_word;
            case (state)
                S_INIT: begin
                    if (init_cnt == LAST_ADDR) begin
                        state     <= S_READY;
                        init_done <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                default: state <= S_READY;
            endcase
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic                  p2_valid;
            logic [DATA_WIDTH-1:0] p2_data;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    p2_valid <= 1'b0;
                    p2_data  <= '0;
                end else begin
                    p2_valid <= p1_valid;
                    if (p1_valid) p2_data <= p1_data;
                end
            end

            assign rd_data  = p2_data;
            assign rd_valid = p2_valid;
        end else begin : g_lat1
            assign rd_data  = p1_data;
            assign rd_valid = p1_valid;
        end
    endgenerate

endmodule

// File: tb/tb_ram_sdp_init.sv
// Randomized self-checking bench: three ram_sdp_init variants (default, 2-cycle read,
// 12-word with non-zero init) share stimulus and are compared against a word-level model.
module tb_ram_sdp_init;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_enb = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;
    logic        rd_enb = 1'b0;
    logic [3:0]  rd_addr = '0;

    logic [31:0] rd_data    [3];
    logic        rd_valid   [3];
    logic        init_done  [3];
    logic        access_err [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ram_sdp_init u_a (
        .clk(clk), .rst(rst), .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(rd_data[0]),
        .rd_valid(rd_valid[0]), .init_done(init_done[0]), .access_err(access_err[0])
    );

    ram_sdp_init #(.RD_LATENCY(2)) u_b (
        .clk(clk), .rst(rst), .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(rd_data[1]),
        .rd_valid(rd_valid[1]), .init_done(init_done[1]), .access_err(access_err[1])
    );

    ram_sdp_init #(.DEPTH(12), .INIT_VALUE(32'h5A5A_0F0F)) u_c (
        .clk(clk), .rst(rst), .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(rd_data[2]),
        .rd_valid(rd_valid[2]), .init_done(init_done[2]), .access_err(access_err[2])
    );

    // Reference model: memory contents, edges since reset release, and a latency delay line.
    int          dep [3] = '{16, 16, 12};
    int          lat [3] = '{1, 2, 1};
    logic [31:0] ini [3] = '{32'h0, 32'h0, 32'h5A5A_0F0F};
    logic [31:0] m_mem [3][16];
    int          m_cnt [3];
    logic        prev_v [3];
    logic [31:0] prev_d [3];
    logic [31:0] exp_data  [3];
    logic        exp_valid [3];
    logic        exp_done  [3];
    logic        exp_err   [3];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0;   prev_v[i] = 1'b0; prev_d[i] = '0;
            exp_data[i] = '0; exp_valid[i] = 1'b0; exp_done[i] = 1'b0; exp_err[i] = 1'b0;
        end
    endtask

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_edge();
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 3; i++) begin
            logic        rv, err, wr_ok, rd_oor;
            logic [31:0] rdw;
            rv = 1'b0; rdw = '0;
            if (m_cnt[i] < dep[i]) begin
                err = wr_enb || rd_enb;
                m_mem[i][m_cnt[i]] = ini[i];
                m_cnt[i]++;
            end else begin
                wr_ok  = wr_enb && (int'(wr_addr) < dep[i]);
                rd_oor = int'(rd_addr) >= dep[i];
                err    = (wr_enb && !wr_ok) || (rd_enb && rd_oor);
                rv     = rd_enb;
                if (rd_enb && !rd_oor) rdw = m_mem[i][rd_addr];
                if (wr_ok) begin
                    m_mem[i][wr_addr] = merge(m_mem[i][wr_addr], wr_data, wr_be);
                    if (rd_enb && !rd_oor && rd_addr == wr_addr) rdw = m_mem[i][wr_addr];
                end
            end
            exp_err[i]  = err;
            exp_done[i] = m_cnt[i] >= dep[i];
            if (lat[i] == 1) begin
                exp_valid[i] = rv;
                if (rv) exp_data[i] = rdw;
            end else begin
                exp_valid[i] = prev_v[i];
                if (prev_v[i]) exp_data[i] = prev_d[i];
                prev_v[i] = rv;
                prev_d[i] = rdw;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("rd_data[%0d]", i),    rd_data[i],          exp_data[i]);
            check_eq($sformatf("rd_valid[%0d]", i),   32'(rd_valid[i]),    32'(exp_valid[i]));
            check_eq($sformatf("init_done[%0d]", i),  32'(init_done[i]),   32'(exp_done[i]));
            check_eq($sformatf("access_err[%0d]", i), 32'(access_err[i]),  32'(exp_err[i]));
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        wr_enb = 1'b0; rd_enb = 1'b0; wr_be = '0;
    endtask

    task automatic rand_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            wr_enb  = ($urandom_range(0, 99) < 50);
            wr_addr = 4'($urandom_range(0, 15));
            wr_data = $urandom;
            wr_be   = 4'($urandom_range(0, 15));
            rd_enb  = ($urandom_range(0, 99) < 60);
            rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
            step();
        end
        idle();
    endtask

    initial begin
        model_reset();
        #3;
        check_all();
        repeat (2) step();

        // Release reset and let the sweep run with requests held low.
        rst = 1'b0;
        idle();
        repeat (16) step();

        for (int a = 0; a < 16; a++) begin
            rd_enb = 1'b1; rd_addr = 4'(a);
            step();
        end
        idle();
        repeat (2) step();

        // Byte-enable partial overwrite.
        wr_enb = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEAD_BEEF; wr_be = 4'b1111;
        step();
        wr_data = 32'h0000_1200; wr_be = 4'b0010;
        step();
        idle(); rd_enb = 1'b1; rd_addr = 4'd3;
        step();
        check_eq("be_merge", rd_data[0], 32'hDEAD_12EF);
        check_eq("be_valid", 32'(rd_valid[0]), 32'd1);
        idle();
        step();

        // Same-address write-first collision.
        wr_enb = 1'b1; wr_addr = 4'd7; wr_data = 32'h1111_1111; wr_be = 4'b1111;
        step();
        wr_data = 32'hA5A5_A5A5; wr_be = 4'b0101; rd_enb = 1'b1; rd_addr = 4'd7;
        step();
        check_eq("wr_first", rd_data[0], 32'h11A5_11A5);
        idle();
        step();

        // Back-to-back reads (exercises the 2-cycle instance ordering).
        for (int a = 0; a < 3; a++) begin
            rd_enb = 1'b1; rd_addr = 4'(a);
            step();
        end
        idle();
        repeat (3) step();

        // Out-of-range accesses (only the 12-word instance errors on 12..15).
        rd_enb = 1'b1; rd_addr = 4'd13;
        step();
        check_eq("oor_rd_data", rd_data[2], 32'h0);
        check_eq("oor_rd_err", 32'(access_err[2]), 32'd1);
        wr_enb = 1'b1; wr_addr = 4'd14; wr_data = 32'hCAFE_F00D; wr_be = 4'hF; rd_enb = 1'b0;
        step();
        wr_be = 4'h0; wr_addr = 4'd2;
        step();
        idle();
        step();

        rand_cycles(300);

        // Asynchronous reset in the middle of traffic.
        wr_enb = 1'b1; rd_enb = 1'b1; rd_addr = 4'd1; wr_addr = 4'd1; wr_be = 4'hF;
        wr_data = 32'h1234_5678;
        step();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        idle();
        repeat (2) step();
        rst = 1'b0;

        wr_enb = 1'b1; wr_addr = 4'd5; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
        step();
        check_eq("init_drop_err", 32'(access_err[0]), 32'd1);
        idle();
        repeat (15) step();
        check_eq("init_redone", 32'(init_done[0]), 32'd1);
        rd_enb = 1'b1; rd_addr = 4'd5;
        step();
        check_eq("init_val_a", rd_data[0], 32'h0);
        check_eq("init_val_c", rd_data[2], 32'h5A5A_0F0F);
        idle();
        step();

        rand_cycles(300);
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
